// File: rtl/bandeja_estoque.sv
// Stock counter for one dispenser tray: multi-digit BCD down-counter with
// low-stock (MC) and empty (BZ) flags, a timed refill sequence and a
// one-cycle error pulse for withdrawals that cannot be honoured.
module bandeja_estoque #(
    parameter int DIGITS        = 2,
    parameter int CAPACITY      = 29,
    parameter int LOW_LEVEL     = 9,
    parameter int REFILL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  retirar,
    input  logic                  reabastecer,
    output logic [4*DIGITS-1:0]   contagem,
    output logic                  MC,
    output logic                  BZ,
    output logic                  repondo,
    output logic                  erro
);

    localparam int CW = 4 * DIGITS;
    localparam int TW = $clog2(REFILL_CYCLES + 1);

    // Decimal-to-BCD conversion, only ever evaluated on constants.
    function automatic logic [CW-1:0] to_bcd(input int value);
        logic [CW-1:0] r;
        int            v;
        r = '0;
        v = value;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Subtract one from a BCD value; a digit at 0 wraps to 9 and borrows.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] value);
        logic [CW-1:0] r;
        logic          borrow;
        r      = value;
        borrow = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (borrow) begin
                if (value[4*d +: 4] == 4'd0) begin
                    r[4*d +: 4] = 4'd9;
                end else begin
                    r[4*d +: 4] = value[4*d +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [CW-1:0] FULL        = to_bcd(CAPACITY);
    localparam logic [CW-1:0] LOW         = to_bcd(LOW_LEVEL);
    localparam logic [TW-1:0] TIMER_START = TW'(REFILL_CYCLES - 1);

    typedef enum logic [1:0] {
        ATIVO,
        VAZIO,
        REPOSICAO
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   count, count_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic            erro_nx;
    logic [CW-1:0]   count_dec;

    // State, count, refill timer and error pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ATIVO;
            count <= FULL;
            timer <= '0;
            erro  <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            timer <= timer_nx;
            erro  <= erro_nx;
        end
    end

    // Next-state logic; a refill request beats a simultaneous withdrawal,
    // which is then dropped and flagged as an error.
    always_comb begin
        state_nx  = state;
        count_nx  = count;
        timer_nx  = timer;
        erro_nx   = 1'b0;
        count_dec = bcd_dec(count);
        case (state)
            ATIVO, VAZIO: begin
                if (reabastecer && (count != FULL)) begin
                    state_nx = REPOSICAO;
                    timer_nx = TIMER_START;
                    erro_nx  = retirar;
                end else if (retirar) begin
                    if (state == ATIVO) begin
                        count_nx = count_dec;
                        if (count_dec == '0) begin
                            state_nx = VAZIO;
                        end
                    end else begin
                        erro_nx = 1'b1;
                    end
                end
            end
            REPOSICAO: begin
                erro_nx = retirar;
                if (timer == '0) begin
                    count_nx = FULL;
                    state_nx = ATIVO;
                end else begin
                    timer_nx = timer - TW'(1);
                end
            end
            default: begin
                state_nx = ATIVO;
            end
        endcase
    end

    // Flags decoded from registered state; BZ is low while refilling, so
    // BZ and MC are never high together.
    always_comb begin
        contagem = count;
        repondo  = (state == REPOSICAO);
        BZ       = (state == VAZIO);
        MC       = (state != REPOSICAO) && (count != '0) && (count <= LOW);
    end

endmodule
